// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage ARM-subset pipeline.
//   INSTR_W / ADDR_W : instruction and address widths
//   NOP_INSTR        : word written into a flushed pipeline slot
//   PC_STEP          : sequential PC increment
//   slot_state_t     : occupancy state of a pipeline register slot
//   if_id_t          : IF/ID register contents, also consumed by decode
package pipeline_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
   localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instruction;
      logic               valid;
   } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush / hold / load controls.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : clear the slot to an empty NOP (highest priority)
//   load      : capture d (ignored while flush is high)
//   d         : incoming pc/instruction (d.valid is ignored; occupancy is
//               tracked by the slot state machine)
//   q         : registered slot contents
// Neither flush nor load means hold.
module if_id_reg
   import pipeline_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   load,
   input  if_id_t d,
   output if_id_t q
);

   slot_state_t        state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (flush) begin
         state_d = SLOT_EMPTY;
         pc_d    = '0;
         instr_d = NOP_INSTR;
      end else if (load) begin
         state_d = SLOT_FULL;
         pc_d    = d.pc;
         instr_d = d.instruction;
      end
   end

   always_comb begin
      q.pc          = pc_q;
      q.instruction = instr_q;
      q.valid       = (state_q == SLOT_FULL);
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, IF/ID register and a
// saturating count of instructions accepted into IF/ID.
//   PC_RESET          : PC value after reset
//   CNT_W             : fetch counter width
//   clk, rst          : clock, asynchronous active-high reset
//   freeze            : hazard stall, holds PC and IF/ID
//   branch_taken      : EXE taken-branch pulse, redirects PC and flushes IF/ID
//   branch_addr       : branch target (low two bits ignored)
//   instruction_in    : combinational instruction-memory word at pc_out
//   pc_out            : current PC
//   if_id_pc          : PC+4 of the latched instruction
//   if_id_instruction : latched instruction
//   if_id_valid       : IF/ID holds a real instruction
//   fetch_count       : instructions accepted since reset, saturating
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             branch_taken,
   input  logic [31:0]      branch_addr,
   input  logic [31:0]      instruction_in,
   output logic [31:0]      pc_out,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_instruction,
   output logic             if_id_valid,
   output logic [CNT_W-1:0] fetch_count
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_plus4;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              load;
   if_id_t            slot_d, slot_q;

   assign pc_plus4 = pc_q + PC_STEP;
   // A branch overrides freeze, so a load only happens when neither is set.
   assign load     = !branch_taken && !freeze;

   always_comb begin
      pc_d = pc_q;
      if (branch_taken) begin
         pc_d = branch_addr & ~ADDR_W'(3);
      end else if (!freeze) begin
         pc_d = pc_plus4;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (load && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= PC_RESET;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      slot_d.pc          = pc_plus4;
      slot_d.instruction = instruction_in;
      slot_d.valid       = 1'b1;
   end

   if_id_reg u_if_id (
      .clk   (clk),
      .rst   (rst),
      .flush (branch_taken),
      .load  (load),
      .d     (slot_d),
      .q     (slot_q)
   );

   assign pc_out            = pc_q;
   assign if_id_pc          = slot_q.pc;
   assign if_id_instruction = slot_q.instruction;
   assign if_id_valid       = slot_q.valid;
   assign fetch_count       = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = '0;
   logic [31:0] instruction_in;
   logic [31:0] pc_out;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;
   logic        if_id_valid;
   logic [15:0] fetch_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Small lab program; other addresses return an address-tagged word.
   function automatic logic [31:0] imem(input logic [31:0] a);
      case (a)
         32'd0:   imem = 32'hE3A00001;
         32'd4:   imem = 32'hE3A01A01;
         32'd8:   imem = 32'hE0802001;
         32'd12:  imem = 32'hE2522001;
         default: imem = 32'hEA000000 ^ a;
      endcase
   endfunction

   assign instruction_in = imem(pc_out);

   fetch_stage #(.PC_RESET(32'h0), .CNT_W(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .freeze            (freeze),
      .branch_taken      (branch_taken),
      .branch_addr       (branch_addr),
      .instruction_in    (instruction_in),
      .pc_out            (pc_out),
      .if_id_pc          (if_id_pc),
      .if_id_instruction (if_id_instruction),
      .if_id_valid       (if_id_valid),
      .fetch_count       (fetch_count)
   );

   // Reference model: what the fetch stage must hold after each edge.
   longint unsigned m_pc, m_ifpc, m_cnt;
   logic [31:0]     m_instr;
   logic            m_valid;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc <= 0; m_ifpc <= 0; m_instr <= '0; m_valid <= 1'b0; m_cnt <= 0;
      end else if (branch_taken) begin
         m_pc    <= (branch_addr / 4) * 4;
         m_ifpc  <= 0;
         m_instr <= '0;
         m_valid <= 1'b0;
      end else if (!freeze) begin
         m_pc    <= (m_pc + 4) % 64'h1_0000_0000;
         m_ifpc  <= (m_pc + 4) % 64'h1_0000_0000;
         m_instr <= imem(m_pc[31:0]);
         m_valid <= 1'b1;
         if (m_cnt < 65535) m_cnt <= m_cnt + 1;
      end
   end

   function automatic void check(input string name, input longint unsigned act,
                                 input longint unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Cycle-by-cycle compare against the model, mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         check("model pc_out",      pc_out,            m_pc);
         check("model if_id_pc",    if_id_pc,          m_ifpc);
         check("model if_id_instr", if_id_instruction, m_instr);
         check("model if_id_valid", if_id_valid,       m_valid);
         check("model fetch_count", fetch_count,       m_cnt);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #3;
      check("reset pc_out",      pc_out,            0);
      check("reset if_id_pc",    if_id_pc,          0);
      check("reset if_id_instr", if_id_instruction, 0);
      check("reset if_id_valid", if_id_valid,       0);
      check("reset fetch_count", fetch_count,       0);
      rst = 1'b0;

      // Three clean fetches.
      step(3);
      check("clean pc_out",      pc_out,            12);
      check("clean if_id_pc",    if_id_pc,          12);
      check("clean if_id_instr", if_id_instruction, 32'hE0802001);
      check("clean fetch_count", fetch_count,       3);

      // Freeze for two cycles at pc_out = 8.
      do_reset();
      step(2);
      check("pre-freeze pc_out", pc_out, 8);
      freeze = 1'b1;
      step(2);
      check("freeze pc_out",      pc_out,            8);
      check("freeze if_id_instr", if_id_instruction, 32'hE3A01A01);
      check("freeze if_id_pc",    if_id_pc,          8);
      check("freeze fetch_count", fetch_count,       2);
      freeze = 1'b0;
      step(1);
      check("release if_id_instr", if_id_instruction, 32'hE0802001);
      check("release if_id_pc",    if_id_pc,          12);
      check("release fetch_count", fetch_count,       3);

      // Branch to 40 from pc_out = 20.
      do_reset();
      step(5);
      check("pre-branch pc_out", pc_out, 20);
      branch_taken = 1'b1; branch_addr = 32'd40;
      step(1);
      branch_taken = 1'b0;
      check("branch pc_out",      pc_out,            40);
      check("branch if_id_valid", if_id_valid,       0);
      check("branch if_id_instr", if_id_instruction, 0);
      check("branch if_id_pc",    if_id_pc,          0);
      step(1);
      check("target if_id_pc",    if_id_pc,          44);
      check("target if_id_valid", if_id_valid,       1);
      check("target if_id_instr", if_id_instruction, 32'hEA000028);
      check("target fetch_count", fetch_count,       6);

      // Branch and freeze together, unaligned target.
      branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h3D;
      step(1);
      branch_taken = 1'b0; freeze = 1'b0;
      check("bf pc_out",      pc_out,      32'h3C);
      check("bf if_id_valid", if_id_valid, 0);
      check("bf fetch_count", fetch_count, 6);

      // Freeze while the slot is empty keeps it empty.
      branch_taken = 1'b1; branch_addr = 32'd100;
      step(1);
      branch_taken = 1'b0; freeze = 1'b1;
      step(1);
      freeze = 1'b0;
      check("empty freeze valid", if_id_valid, 0);
      check("empty freeze pc",    pc_out,      100);

      // PC wrap.
      branch_taken = 1'b1; branch_addr = 32'hFFFFFFFC;
      step(1);
      branch_taken = 1'b0;
      check("wrap pc before", pc_out, 32'hFFFFFFFC);
      step(1);
      check("wrap pc_out",   pc_out,   0);
      check("wrap if_id_pc", if_id_pc, 0);
      check("wrap valid",    if_id_valid, 1);

      // Asynchronous reset mid-cycle with a branch pending.
      branch_taken = 1'b1; branch_addr = 32'h80;
      #2;
      rst = 1'b1;
      #1;
      check("async pc_out",      pc_out,            0);
      check("async if_id_pc",    if_id_pc,          0);
      check("async if_id_instr", if_id_instruction, 0);
      check("async if_id_valid", if_id_valid,       0);
      check("async fetch_count", fetch_count,       0);
      branch_taken = 1'b0;
      rst = 1'b0;
      step(1);
      check("restart pc_out",      pc_out,            4);
      check("restart if_id_instr", if_id_instruction, 32'hE3A00001);
      check("restart fetch_count", fetch_count,       1);

      // Counter saturation.
      do_reset();
      step(65535);
      check("sat reach", fetch_count, 16'hFFFF);
      step(5);
      check("sat hold", fetch_count, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
